// File: rtl/tea_pkg.sv
// tea_pkg: constants, enums and helpers shared by the TEA/XTEA core.
// Holds the round constant, algorithm select and FSM state encodings.
package tea_pkg;

    localparam logic [31:0] DELTA = 32'h9E37_79B9;

    typedef enum logic {
        ALGO_TEA  = 1'b0,
        ALGO_XTEA = 1'b1
    } algo_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Starting sum for decryption: DELTA*rounds, wrapped to 32 bits.
    function automatic logic [31:0] delta_sum(input int rounds);
        logic [63:0] prod;
        prod = 64'(DELTA) * 64'(rounds);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/tea_iterative_param_if.sv
// tea_iterative_param_if: input and output stream bundles of the core.
// master drives blocks in and takes results; slave is the core side.
interface tea_iterative_param_if;

    logic [63:0] s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tuser,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tuser,
        input  m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tuser,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tuser,
        output m_axis_tvalid,
        input  m_axis_tready
    );

endinterface

// File: rtl/tea_round.sv
// tea_round: one combinational TEA or XTEA cycle (two Feistel rounds).
// mode_i=0 runs forward (encrypt), mode_i=1 runs the exact inverse.
module tea_round
    import tea_pkg::*;
#(
    parameter int ALGO = 0
) (
    input  logic [63:0]  v_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    input  logic         mode_i,
    output logic [63:0]  v_o,
    output logic [31:0]  sum_o
);

    function automatic logic [31:0] kw(
        input logic [127:0] k,
        input logic [1:0]   i
    );
        logic [31:0] w;
        case (i)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] tea_f(
        input logic [31:0] x,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    function automatic logic [31:0] xtea_f(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;

    // One full cycle; the second half-round sees the updated first word.
    always_comb begin
        y = v_i[63:32];
        z = v_i[31:0];
        s = sum_i;
        if (ALGO == int'(ALGO_XTEA)) begin
            if (!mode_i) begin
                y = y + (xtea_f(z) ^ (s + kw(key_i, s[1:0])));
                s = s + DELTA;
                z = z + (xtea_f(y) ^ (s + kw(key_i, s[12:11])));
            end else begin
                z = z - (xtea_f(y) ^ (s + kw(key_i, s[12:11])));
                s = s - DELTA;
                y = y - (xtea_f(z) ^ (s + kw(key_i, s[1:0])));
            end
        end else begin
            if (!mode_i) begin
                s = s + DELTA;
                y = y + tea_f(z, s, key_i[127:96], key_i[95:64]);
                z = z + tea_f(y, s, key_i[63:32], key_i[31:0]);
            end else begin
                z = z - tea_f(y, s, key_i[63:32], key_i[31:0]);
                y = y - tea_f(z, s, key_i[127:96], key_i[95:64]);
                s = s - DELTA;
            end
        end
        v_o   = {y, z};
        sum_o = s;
    end

endmodule

// File: rtl/tea_iterative_param.sv
// tea_iterative_param: iterative TEA/XTEA block cipher core.
// UNROLL chained cycles per clock, ROUNDS/UNROLL clocks per block.
module tea_iterative_param
    import tea_pkg::*;
#(
    parameter int ALGO   = 0,
    parameter int ROUNDS = 32,
    parameter int UNROLL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [127:0]         key,
    output logic                 busy,
    tea_iterative_param_if.slave bus
);

    localparam int STEPS = ROUNDS / UNROLL;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [31:0] DEC_SUM = delta_sum(ROUNDS);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   v_q, v_d;
    logic [31:0]   sum_q, sum_d;
    logic [127:0]  key_q, key_d;
    logic          mode_q, mode_d;

    logic [63:0]   chain_v [UNROLL+1];
    logic [31:0]   chain_s [UNROLL+1];

    assign chain_v[0] = v_q;
    assign chain_s[0] = sum_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        tea_round #(
            .ALGO (ALGO)
        ) u_round (
            .v_i    (chain_v[i]),
            .sum_i  (chain_s[i]),
            .key_i  (key_q),
            .mode_i (mode_q),
            .v_o    (chain_v[i+1]),
            .sum_o  (chain_s[i+1])
        );
    end

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
        end
    end

    // Next state: capture on input handshake, iterate, hold until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        sum_d   = sum_q;
        key_d   = key_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.s_axis_tvalid) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    v_d     = bus.s_axis_tdata;
                    key_d   = key;
                    mode_d  = bus.s_axis_tuser;
                    sum_d   = bus.s_axis_tuser ? DEC_SUM : 32'd0;
                end
            end
            ST_RUN: begin
                v_d   = chain_v[UNROLL];
                sum_d = chain_s[UNROLL];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.m_axis_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.s_axis_tready = (state_q == ST_IDLE);
    assign bus.m_axis_tvalid = (state_q == ST_DONE);
    assign bus.m_axis_tdata  = v_q;
    assign bus.m_axis_tuser  = mode_q;
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_tea_iterative_param.sv
// tb_tea_iterative_param: directed checks of four core variants.
// TEA/XTEA at UNROLL 1, TEA at UNROLL 4, XTEA at UNROLL 8, in lockstep.
module tb_tea_iterative_param;
    import tea_pkg::*;

    localparam int NDUT = 4;
    localparam int ALG [NDUT] = '{0, 1, 0, 1};
    localparam int UNR [NDUT] = '{1, 1, 4, 8};
    localparam logic [63:0] Z_TEA  = 64'h41EA_3A0A_94BA_A940;
    localparam logic [63:0] Z_XTEA = 64'hDEE9_D4D8_F713_1ED9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [127:0]          key_in;
    logic [NDUT-1:0][63:0] s_data;
    logic [NDUT-1:0][63:0] m_data;
    logic                  s_user;
    logic                  s_valid;
    logic                  m_ready;
    logic [NDUT-1:0]       s_ready;
    logic [NDUT-1:0]       m_user;
    logic [NDUT-1:0]       m_valid;
    logic [NDUT-1:0]       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        tea_iterative_param_if u_if ();
        assign u_if.s_axis_tdata  = s_data[g];
        assign u_if.s_axis_tuser  = s_user;
        assign u_if.s_axis_tvalid = s_valid;
        assign u_if.m_axis_tready = m_ready;
        assign s_ready[g] = u_if.s_axis_tready;
        assign m_data[g]  = u_if.m_axis_tdata;
        assign m_user[g]  = u_if.m_axis_tuser;
        assign m_valid[g] = u_if.m_axis_tvalid;

        tea_iterative_param #(
            .ALGO   (ALG[g]),
            .ROUNDS (32),
            .UNROLL (UNR[g])
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .key  (key_in),
            .busy (busy[g]),
            .bus  (u_if)
        );
    end

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Straight 32-cycle reference encryption, written as the C loop.
    function automatic logic [63:0] ref_enc(
        input int           alg,
        input logic [127:0] k,
        input logic [63:0]  d
    );
        logic [31:0] kk [4];
        logic [31:0] y, z, s;
        kk[0] = k[127:96];
        kk[1] = k[95:64];
        kk[2] = k[63:32];
        kk[3] = k[31:0];
        y = d[63:32];
        z = d[31:0];
        s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (alg == 0) begin
                s = s + 32'h9E3779B9;
                y = y + (((z << 4) + kk[0]) ^ (z + s) ^ ((z >> 5) + kk[1]));
                z = z + (((y << 4) + kk[2]) ^ (y + s) ^ ((y >> 5) + kk[3]));
            end else begin
                y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kk[s[1:0]]));
                s = s + 32'h9E3779B9;
                z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kk[s[12:11]]));
            end
        end
        return {y, z};
    endfunction

    task automatic run_block(
        input  logic [NDUT-1:0][63:0] din,
        input  logic                  user,
        input  logic [127:0]          k,
        input  bit                    toggle,
        input  int                    hold,
        input  string                 tag,
        output logic [NDUT-1:0][63:0] dout
    );
        int                    lat [NDUT];
        int                    c;
        bit                    stable;
        logic [NDUT-1:0]       seen;
        logic [NDUT-1:0][63:0] snap;
        logic [NDUT-1:0]       uout;
        @(negedge clk);
        s_data  = din;
        s_user  = user;
        key_in  = k;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_rdy_low"}, 64'(s_ready), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'({NDUT{1'b1}}));
        seen = '0;
        c    = 0;
        for (int g = 0; g < NDUT; g++) lat[g] = 0;
        while (seen != {NDUT{1'b1}} && c < 200) begin
            if (toggle) begin
                key_in = ~key_in;
                s_user = ~s_user;
            end
            @(negedge clk);
            c++;
            for (int g = 0; g < NDUT; g++) begin
                if (m_valid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = c;
                end
            end
        end
        check({tag, "_done"}, 64'(seen), 64'({NDUT{1'b1}}));
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_lat%0d", tag, g), 64'(lat[g]), 64'(32 / UNR[g]));
        end
        snap   = m_data;
        uout   = m_user;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (m_data !== snap || m_valid !== {NDUT{1'b1}} ||
                s_ready !== '0 || m_user !== uout) begin
                stable = 1'b0;
            end
        end
        if (hold > 0) begin
            check({tag, "_hold"}, 64'(stable), 64'(1));
        end
        check({tag, "_user"}, 64'(uout), 64'({NDUT{user}}));
        dout = m_data;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_xfer_once"}, 64'(m_valid), 64'(0));
        check({tag, "_rdy_back"}, 64'(s_ready), 64'({NDUT{1'b1}}));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NDUT-1:0][63:0] din;
        logic [NDUT-1:0][63:0] enc;
        logic [NDUT-1:0][63:0] dec;
        logic [127:0]          k;
        logic [63:0]           d;

        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_user  = 1'b0;
        key_in  = '0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'({NDUT{1'b1}}));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_m_user", 64'(m_user), 64'(0));
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst_m_data%0d", g), m_data[g], 64'd0);
        end
        rst = 1'b0;

        din = '0;
        run_block(din, 1'b0, 128'd0, 1'b0, 50, "zenc", enc);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("zenc_data%0d", g), enc[g],
                  (ALG[g] == 1) ? Z_XTEA : Z_TEA);
        end

        for (int g = 0; g < NDUT; g++) begin
            din[g] = (ALG[g] == 1) ? Z_XTEA : Z_TEA;
        end
        run_block(din, 1'b1, 128'd0, 1'b0, 0, "zdec", dec);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("zdec_data%0d", g), dec[g], 64'd0);
        end

        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom};
            for (int g = 0; g < NDUT; g++) din[g] = d;
            run_block(din, 1'b0, k, 1'b1, 0, $sformatf("renc%0d", t), enc);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("renc%0d_data%0d", t, g), enc[g],
                      ref_enc(ALG[g], k, d));
            end
            run_block(enc, 1'b1, k, 1'b1, 0, $sformatf("rdec%0d", t), dec);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("rdec%0d_data%0d", t, g), dec[g], d);
            end
        end

        @(negedge clk);
        s_data  = {NDUT{64'h0123_4567_89AB_CDEF}};
        s_user  = 1'b0;
        key_in  = 128'h1;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", 64'(s_ready), 64'({NDUT{1'b1}}));
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        din = '0;
        run_block(din, 1'b0, 128'd0, 1'b0, 0, "post_rst", enc);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("post_rst_data%0d", g), enc[g],
                  (ALG[g] == 1) ? Z_XTEA : Z_TEA);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tea_iterative_param.md
TEA_ITERATIVE_PARAM -- requirements
Module: tea_iterative_param

Interface
REQ-001 Parameter ALGO, default 0: 0 = TEA, 1 = XTEA round function.
REQ-002 Parameter ROUNDS, default 32: full cycles (Feistel double-rounds) per block; legal values 1..64.
REQ-003 Parameter UNROLL, default 1: cycles computed per clock; must divide ROUNDS; legal values 1, 2, 4, 8.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 key  in  128  k0=key[127:96] .. k3=key[31:0]; sampled only at input handshake.
REQ-007 s_axis_tdata  in  64  v0=[63:32], v1=[31:0].
REQ-008 s_axis_tuser  in  1  0 = encrypt, 1 = decrypt; sampled at input handshake.
REQ-009 s_axis_tvalid  in  1  input block valid.
REQ-010 s_axis_tready  out  1  core can accept a block.
REQ-011 m_axis_tdata  out  64  result, same word order as input.
REQ-012 m_axis_tuser  out  1  mode of the block being output.
REQ-013 m_axis_tvalid  out  1  result valid.
REQ-014 m_axis_tready  in  1  downstream accepts result.
REQ-015 busy  out  1  high in RUN or DONE.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on s_axis_tvalid&&s_axis_tready; RUN->DONE when round counter reaches ROUNDS/UNROLL-1; DONE->IDLE on m_axis_tvalid&&m_axis_tready.
REQ-017 s_axis_tready = (state==IDLE); m_axis_tvalid = (state==DONE); both combinational from state only.
REQ-018 At input handshake: latch v0, v1, key, mode; counter=0; sum=0 for encrypt, sum=DELTA*ROUNDS mod 2^32 for decrypt (0xC6EF3720 at ROUNDS=32); DELTA=0x9E3779B9.
REQ-019 In RUN each clock applies UNROLL chained cycles to the state registers and increments counter by 1.
REQ-020 TEA encrypt cycle: sum+=DELTA; v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1); v1+=((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3); decrypt is exact inverse order (v1 first, then v0, then sum-=DELTA).
REQ-021 XTEA encrypt cycle: v0+=(((v1<<4)^(v1>>5))+v1)^(sum+k[sum[1:0]]); sum+=DELTA; v1+=(((v0<<4)^(v0>>5))+v0)^(sum+k[sum[12:11]]); decrypt is exact inverse; k[0]=k0.
REQ-022 All arithmetic 32-bit modulo 2^32; shifts logical.
REQ-023 Latency: m_axis_tvalid rises exactly ROUNDS/UNROLL clocks after the input-handshake edge (32 at defaults).
REQ-024 In DONE, m_axis_tdata/m_axis_tuser held stable until handshake; backpressure of any length loses nothing.
REQ-025 s_axis_tready is low from the handshake edge until the clock after the output handshake; minimum block period ROUNDS/UNROLL+2 clocks.
REQ-026 Changes on key or s_axis_tuser after input handshake do not affect the block in flight.
REQ-027 m_axis_tdata is don't-care outside DONE but drives the state register (no extra mux).

Reset
REQ-028 rst takes priority over all events, including any mid-RUN or in-DONE state; state=IDLE, counter=0, block discarded.
REQ-029 After reset: s_axis_tready=1, m_axis_tvalid=0, busy=0, m_axis_tuser=0, m_axis_tdata=0.

Structure
REQ-030 Package tea_pkg holds DELTA, the algo enum, the FSM state enum and a function returning DELTA*ROUNDS.
REQ-031 One sub-module tea_round: combinational single cycle, parameters ALGO, inputs v, sum, key, mode, outputs next v and sum; instantiated UNROLL times in a chain.
REQ-032 Round counter width $clog2(ROUNDS/UNROLL) (minimum 1 bit).

Verification
REQ-033 ALGO=0, key=0, data=0, encrypt -> 0x41EA3A0A94BAA940 after exactly 32 clocks; tuser=0.
REQ-034 ALGO=1, key=0, data=0, encrypt -> 0xDEE9D4D8F7131ED9; decrypt of that with key=0 -> 0.
REQ-035 100 random key/data per ALGO and UNROLL in {1,2,4,8}: encrypt, then decrypt result -> original data; output compared against C reference model.
REQ-036 Hold m_axis_tready=0 for 50 clocks in DONE -> tdata stable, s_axis_tready=0, single transfer on release.
REQ-037 Assert rst at RUN counter=10 -> next clock s_axis_tready=1, m_axis_tvalid=0; following block yields correct result.
REQ-038 Toggle key and s_axis_tuser every clock during RUN -> result equals value for the key/mode captured at handshake.
